// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt/exception request and eret target.
// Req is combinational from the commit-point inputs; all register state updates on clk.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_3007,
  parameter logic [5:0]  IM_RESET   = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  im;
  logic [5:0]  ip;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic [31:0] sr;
  logic [31:0] cause;
  logic        int_req;
  logic        exc_req;
  logic        unused_din;

  assign unused_din = ^{DIn[31:16], DIn[9:2]};

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
  assign Req     = int_req | exc_req;

  assign sr    = {16'b0, im, 8'b0, exl, ie};
  assign cause = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= IM_RESET;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'b0;
      exc_code <= 5'b0;
      epc      <= 32'b0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        // Taking the exception wins over any mtc0 committing in the same cycle.
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - 32'd4) : VPC;
      end else begin
        if (EXLClr)
          exl <= 1'b0;
        if (WE) begin
          if (A2 == 5'd12) begin
            im  <= DIn[15:10];
            exl <= DIn[1] & ~EXLClr;
            ie  <= DIn[0];
          end else if (A2 == 5'd14) begin
            epc <= DIn;
          end
        end
      end
    end
  end

  always_comb begin
    DOut = 32'b0;
    case (A1)
      5'd12:   DOut = sr;
      5'd13:   DOut = cause;
      5'd14:   DOut = epc;
      5'd15:   DOut = PRID_VALUE;
      default: DOut = 32'b0;
    endcase
  end

  // Forward an mtc0 EPC committing now so an eret right behind it sees the new value.
  assign EPCOut = (WE && !Req && A2 == 5'd14) ? DIn : epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed walk through the exception/eret flows, then random
// cycles, all checked against a register-word level model of CP0.
module tb_cp0_unit;
  localparam logic [31:0] PRID = 32'h0000_3007;
  localparam logic [5:0]  IMR  = 6'b000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  A1 = '0, A2 = '0, ExcCodeIn = '0;
  logic [31:0] DIn = '0, VPC = '0;
  logic        WE = 1'b0, BDIn = 1'b0, EXLClr = 1'b0;
  logic [5:0]  HWInt = '0;
  logic [31:0] DOut, EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_sr, m_cause, m_epc;
  logic        obs_req;

  cp0_unit #(.PRID_VALUE(PRID), .IM_RESET(IMR)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE), .VPC(VPC),
    .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_regs();
    logic [4:0] other;
    for (int a = 12; a <= 15; a++) begin
      A1 = 5'(a);
      #1;
      chk($sformatf("dout_r%0d", a), DOut, model_read(5'(a)));
    end
    other = 5'($urandom_range(0, 31));
    A1 = other;
    #1;
    chk($sformatf("dout_r%0d", other), DOut, model_read(other));
  endtask

  task automatic step(input logic rst, input logic we, input logic [4:0] a2,
                      input logic [31:0] din, input logic [31:0] vpc, input logic bd,
                      input logic [4:0] exc, input logic [5:0] hw, input logic eret);
    logic ireq, ereq, mreq;
    reset = rst; WE = we; A2 = a2; DIn = din; VPC = vpc; BDIn = bd;
    ExcCodeIn = exc; HWInt = hw; EXLClr = eret;
    #1;
    ireq = ((hw & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
    ereq = (exc != 5'd0) && !m_sr[1];
    mreq = ireq || ereq;
    obs_req = Req;
    if (!rst) begin
      chk("req", {31'b0, Req}, {31'b0, mreq});
      chk("epcout", EPCOut, (we && !mreq && a2 == 5'd14) ? din : m_epc);
    end
    @(posedge clk);
    if (rst) begin
      m_sr    = 32'(IMR) << 10;
      m_cause = 32'h0;
      m_epc   = 32'h0;
    end else if (mreq) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (32'(bd) << 31) | (32'(hw) << 10) | ((ireq ? 32'h0 : 32'(exc)) << 2);
      m_epc   = bd ? vpc - 32'd4 : vpc;
    end else begin
      if (eret) m_sr = m_sr & ~32'h2;
      if (we && a2 == 5'd12) m_sr = (din & 32'h0000_FC03) & (eret ? ~32'h2 : ~32'h0);
      if (we && a2 == 5'd14) m_epc = din;
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
    end
    #1;
    check_regs();
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  initial begin
    m_sr = 'x; m_cause = 'x; m_epc = 'x;
    #2;
    // reset and read-back of reset values
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_chk("prid", 5'd15, 32'h0000_3007);
    rd_chk("sr_reset", 5'd12, 32'h0);
    // enable IM[10]/IE, then take interrupt on line 0
    step(0, 1, 12, 32'h0000_0401, 0, 0, 0, 6'b000000, 0);
    step(0, 0, 0, 0, 32'h3010, 0, 0, 6'b000001, 0);
    chk("int_req", {31'b0, obs_req}, 32'h1);
    rd_chk("sr_int", 5'd12, 32'h0000_0403);
    rd_chk("cause_int", 5'd13, 32'h0000_0400);
    rd_chk("epc_int", 5'd14, 32'h0000_3010);
    step(0, 0, 0, 0, 32'h3014, 0, 5'd10, 6'b000001, 0);
    chk("req_masked_by_exl", {31'b0, obs_req}, 32'h0);
    // eret with interrupt still pending: Req returns the cycle after
    step(0, 0, 0, 0, 0, 0, 0, 6'b000001, 1);
    chk("req_during_eret", {31'b0, obs_req}, 32'h0);
    step(0, 0, 0, 0, 32'h3018, 0, 0, 6'b000001, 0);
    chk("req_after_eret", {31'b0, obs_req}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // RI exception in delay slot
    step(0, 0, 0, 0, 32'h3024, 1, 5'd10, 0, 0);
    chk("exc_req", {31'b0, obs_req}, 32'h1);
    rd_chk("cause_exc", 5'd13, 32'h8000_0028);
    rd_chk("epc_exc", 5'd14, 32'h0000_3020);
    // eret plus coincident SR write keeps EXL clear
    step(0, 1, 12, 32'h0000_0403, 0, 0, 0, 0, 1);
    rd_chk("sr_eret_we", 5'd12, 32'h0000_0401);
    // mtc0 EPC bypass, then a write dropped by an exception
    step(0, 1, 14, 32'h0000_3100, 0, 0, 0, 0, 0);
    rd_chk("epc_write", 5'd14, 32'h0000_3100);
    step(0, 1, 14, 32'h0000_5555, 32'h3040, 0, 5'd4, 0, 0);
    rd_chk("epc_dropped", 5'd14, 32'h0000_3040);
    step(0, 1, 12, 32'h0000_0000, 0, 0, 0, 0, 1);
    // pending but masked interrupt only shows in Cause.IP
    step(0, 0, 0, 0, 0, 0, 0, 6'b100000, 0);
    chk("req_im0", {31'b0, obs_req}, 32'h0);
    A1 = 5'd13; #1;
    chk("cause_ip", DOut & 32'h0000_FC00, 32'h0000_8000);
    step(1, 1, 14, 32'h1234_5678, 32'h4000, 1, 5'd12, 6'b100000, 0);
    rd_chk("epc_after_reset", 5'd14, 32'h0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a2r;
      logic [5:0] hwr;
      a2r = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      hwr = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, a2r,
           ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'($urandom) & 32'h0000_FC03),
           32'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
           hwr, $urandom_range(0, 3) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
